mac_stream_pe: RTL and testbench
================================

Name: mac_stream_pe

Overview:
- Next-generation dot-product processing element for the SIMD array. It is parametrised in operand width and vector depth, and supports a signed or unsigned mode per operation.
- Operand pairs arrive over a valid/ready load stream and are buffered in internal A/B storage. A sequential multiply-accumulate then runs at one element per cycle.
- The result is saturated to operand width and returned over a valid/ready output handshake.
- The array controller drives START/LEN and the data streams. Results feed the array's output collector.

Parameters:
- DW, 32, operand and result width in bits.
- DEPTH, 16, maximum vector length (number of A/B entries).
- ACC_W, 2*DW+$clog2(DEPTH), accumulator width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- START  input  1  begin an operation; sampled only in IDLE.
- LEN  input  $clog2(DEPTH+1)  vector length, latched on START.
- SIGNED  input  1  1 = two's-complement operands and result; latched on START.
- IN_VALID  input  1  load beat valid.
- IN_READY  output  1  PE accepts a load beat.
- IN_A  input  DW  A element.
- IN_B  input  DW  B element.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- OUT_DATA  output  DW  saturated dot product; 0 when OUT_VALID=0.
- OUT_SAT  output  1  result was clipped; 0 when OUT_VALID=0.
- BUSY  output  1  state is not IDLE.

Behaviour:
- Reset (RSTN=0, takes effect immediately):
  - State goes to IDLE.
  - IN_READY, OUT_VALID, OUT_SAT and BUSY are 0; OUT_DATA is 0.
  - Accumulator and all counters are 0. A/B storage is not cleared.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- FSM states: IDLE, LOAD, MAC, DONE.
- IDLE:
  - On START=1, latch SIGNED and LEN. LEN above DEPTH is clamped to DEPTH.
  - Clear the accumulator, write address and element index.
  - Go to LOAD, or to DONE if LEN=0 (result 0, OUT_SAT=0).
- LOAD:
  - IN_READY=1.
  - Each cycle with IN_VALID & IN_READY writes IN_A/IN_B to entry ADDR and increments ADDR.
  - The edge accepting beat LEN-1 moves to MAC with IN_READY low from the next cycle.
  - Gaps in IN_VALID stall LOAD indefinitely.
- MAC:
  - Each edge computes ACC += A[idx]*B[idx] and increments idx.
  - The product is the full 2*DW bits, sign-extended (SIGNED=1) or zero-extended to ACC_W.
  - ACC wraps modulo 2^ACC_W; the default ACC_W cannot overflow.
  - The edge processing idx=LEN-1 moves to DONE.
  - OUT_VALID therefore rises exactly LEN edges after the edge that accepted the last load beat.
- DONE:
  - OUT_VALID=1.
  - Saturation when SIGNED=1: ACC is clipped to [-2^(DW-1), 2^(DW-1)-1].
  - Saturation when SIGNED=0: ACC is clipped to [0, 2^DW-1].
  - OUT_SAT=1 if clipping occurred.
  - OUT_DATA and OUT_SAT hold stable while OUT_READY=0.
  - The edge with OUT_READY=1 returns to IDLE.
- START is ignored while BUSY=1, including START asserted in the same cycle as the output handshake. A new START is accepted only in the following IDLE cycle.
- IN_VALID outside LOAD is ignored, and no write occurs.
- Stale A/B entries beyond LEN never contribute to the result.

Test Plan:
- SIGNED=0, LEN=4, A={1,2,3,4}, B={5,6,7,8}, back-to-back beats, OUT_READY=1 -> OUT_DATA=70, OUT_SAT=0, OUT_VALID high 4 edges after the last beat, one-cycle pulse, BUSY low the next cycle.
- SIGNED=1, LEN=2, A={-3,4}, B={5,-6} -> OUT_DATA=0xFFFFFFD9 (-39), OUT_SAT=0.
- Saturation:
  - SIGNED=0, LEN=2, A=B={0xFFFFFFFF,0xFFFFFFFF} -> OUT_DATA=0xFFFFFFFF, OUT_SAT=1.
  - SIGNED=1, LEN=1, A=B=0x80000000 -> OUT_DATA=0x7FFFFFFF, OUT_SAT=1.
  - SIGNED=1, LEN=1, A=0x80000000, B=0x7FFFFFFF -> OUT_DATA=0x80000000, OUT_SAT=1.
- Handshakes: LEN=3 with IN_VALID toggled every other cycle, OUT_READY held 0 for 5 cycles, START pulsed while BUSY -> result 1*1+2*2+3*3=14 held stable for the whole stall, extra START ignored.
- Boundaries:
  - LEN=0 -> OUT_VALID the cycle after START, OUT_DATA=0.
  - LEN=17 with DEPTH=16 -> exactly 16 beats accepted.
  - LEN=16, all A=B=1 -> 16.
- RSTN pulsed low mid-MAC (LEN=4) -> outputs 0 immediately, state IDLE. Then run LEN=1, A=2, B=3 -> OUT_DATA=6, with no residue from the aborted run.

Source files
------------

// File: rtl/mac_stream_pe.sv
// mac_stream_pe: dot-product processing element for the SIMD array.
// Operand pairs are buffered from a valid/ready load stream, multiplied and
// accumulated one element per cycle, then the sum is saturated to DW bits and
// returned over a valid/ready result handshake.
module mac_stream_pe #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ACC_W = 2 * DW + $clog2(DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       START,
    input  logic [$clog2(DEPTH+1)-1:0] LEN,
    input  logic                       SIGNED,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [DW-1:0]              IN_A,
    input  logic [DW-1:0]              IN_B,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [DW-1:0]              OUT_DATA,
    output logic                       OUT_SAT,
    output logic                       BUSY
);

    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned EXT_W = ACC_W - PW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [LW-1:0]     len_q;
    logic              sgn_q;
    logic [LW-1:0]     addr;
    logic [LW-1:0]     idx;
    logic [ACC_W-1:0]  acc;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic              out_sat_q;
    logic              busy_q;

    logic [DW-1:0]     a_mem [DEPTH];
    logic [DW-1:0]     b_mem [DEPTH];

    logic [LW-1:0]     len_clamp;
    logic [DW-1:0]     a_cur;
    logic [DW-1:0]     b_cur;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-DW:0] hi_s;
    logic [ACC_W-DW-1:0] hi_u;
    logic [DW-1:0]     sat_data;
    logic              sat_flag;

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_SAT   = out_sat_q;
    assign BUSY      = busy_q;

    // Clamp requested length to the storage depth
    assign len_clamp = (LEN > LW'(DEPTH)) ? LW'(DEPTH) : LEN;

    // Operand fetch for the current MAC element
    assign a_cur = a_mem[IW'(idx)];
    assign b_cur = b_mem[IW'(idx)];

    // Full-width product, extended to the accumulator per operation mode
    always_comb begin
        a_ext    = {{DW{1'b0}}, a_cur};
        b_ext    = {{DW{1'b0}}, b_cur};
        if (sgn_q) begin
            a_ext = {{DW{a_cur[DW-1]}}, a_cur};
            b_ext = {{DW{b_cur[DW-1]}}, b_cur};
        end
        prod     = a_ext * b_ext;
        prod_ext = {{EXT_W{1'b0}}, prod};
        if (sgn_q) begin
            prod_ext = {{EXT_W{prod[PW-1]}}, prod};
        end
        acc_sum  = acc + prod_ext;
    end

    // Clip the final accumulator value to the DW-bit result range
    always_comb begin
        hi_s     = acc_sum[ACC_W-1:DW-1];
        hi_u     = acc_sum[ACC_W-1:DW];
        sat_data = acc_sum[DW-1:0];
        sat_flag = 1'b0;
        if (sgn_q) begin
            if ((hi_s != '0) && (hi_s != '1)) begin
                sat_flag = 1'b1;
                sat_data = acc_sum[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}}
                                            : {1'b0, {(DW-1){1'b1}}};
            end
        end else if (hi_u != '0) begin
            sat_flag = 1'b1;
            sat_data = '1;
        end
    end

    // Operand storage write port; not reset, only written while loading
    always_ff @(posedge CLK) begin
        if ((state == LOAD) && IN_VALID) begin
            a_mem[IW'(addr)] <= IN_A;
            b_mem[IW'(addr)] <= IN_B;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            len_q       <= '0;
            sgn_q       <= 1'b0;
            addr        <= '0;
            idx         <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        len_q  <= len_clamp;
                        sgn_q  <= SIGNED;
                        acc    <= '0;
                        addr   <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        if (len_clamp == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_sat_q   <= 1'b0;
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (IN_VALID) begin
                        addr <= addr + LW'(1);
                        if (addr == len_q - LW'(1)) begin
                            state      <= MAC;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + LW'(1);
                    if (idx == len_q - LW'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sat_data;
                        out_sat_q   <= sat_flag;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_sat_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_pe.sv
// Bench for mac_stream_pe: table-driven vectors, hand-written handshake,
// boundary and reset sequences, and a few random operations.
module tb_mac_stream_pe;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          START;
    logic [LW-1:0] LEN;
    logic          SIGNED;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] IN_A;
    logic [DW-1:0] IN_B;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_SAT;
    logic          BUSY;

    mac_stream_pe #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .START     (START),
        .LEN       (LEN),
        .SIGNED    (SIGNED),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_SAT   (OUT_SAT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit                  sgn;
        int                  len;
        logic [15:0][31:0]   a;
        logic [15:0][31:0]   b;
        logic [31:0]         exp_d;
        bit                  exp_s;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        bit          s;
    } exp_t;

    vec_t        vecs [6];
    exp_t        sb [$];
    logic [31:0] beat_a [32];
    logic [31:0] beat_b [32];
    int          checks   = 0;
    int          failures = 0;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: wide arithmetic, then range comparison
    task automatic model(input bit sgn, input int len, output logic [31:0] d, output bit s);
        logic signed [127:0] sum;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            if (sgn) sum = sum + 128'($signed(beat_a[i])) * 128'($signed(beat_b[i]));
            else     sum = sum + $signed({96'd0, beat_a[i]}) * $signed({96'd0, beat_b[i]});
        end
        s = 1'b0;
        d = sum[31:0];
        if (sgn) begin
            if (sum > 128'sd2147483647)       begin d = 32'h7FFFFFFF; s = 1'b1; end
            else if (sum < -128'sd2147483648) begin d = 32'h80000000; s = 1'b1; end
        end else if (sum > 128'sd4294967295) begin
            d = 32'hFFFFFFFF; s = 1'b1;
        end
    endtask

    task automatic load(input int n, input bit gap, output int accepted);
        int  cycles;
        logic ok;
        accepted = 0;
        cycles   = 0;
        while (accepted < n && cycles < 200) begin
            IN_VALID = 1'b1;
            IN_A     = beat_a[accepted];
            IN_B     = beat_b[accepted];
            ok       = IN_READY;
            tick();
            cycles++;
            if (ok) accepted++;
            if (gap && accepted < n) begin
                IN_VALID = 1'b0;
                tick();
                cycles++;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!OUT_VALID && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!OUT_VALID) check({nm, "_timeout"}, 64'(OUT_VALID), 64'd1);
        else if (exp_lat >= 0) check({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got result %0h expected none", nm, OUT_DATA);
        end else begin
            e = sb.pop_front();
            check({nm, "_data"}, 64'(OUT_DATA), 64'(e.d));
            check({nm, "_sat"},  64'(OUT_SAT),  64'(e.s));
        end
    endtask

    task automatic run_op(input bit sgn, input int len, input logic [31:0] ed,
                          input bit es, input bit gap, input string nm);
        int acc;
        sb.push_back(exp_t'{d: ed, s: es});
        START  = 1'b1;
        SIGNED = sgn;
        LEN    = LW'(len);
        tick();
        START  = 1'b0;
        load(len, gap, acc);
        check({nm, "_beats"}, 64'(acc), 64'(len));
        wait_result(nm, len);
        tick();
        check({nm, "_pulse"}, 64'({OUT_VALID, BUSY}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic [31:0] md;
        bit          ms;
        bit          rs;
        int          rl;

        RSTN = 1'b0; START = 1'b0; LEN = '0; SIGNED = 1'b0;
        IN_VALID = 1'b0; IN_A = '0; IN_B = '0; OUT_READY = 1'b1;
        tick();
        tick();
        check("reset_outs", 64'({IN_READY, OUT_VALID, OUT_SAT, BUSY}), 64'd0);
        check("reset_data", 64'(OUT_DATA), 64'd0);
        RSTN = 1'b1;
        tick();

        // Vector table; LEN=16 first so later shorter ops see stale entries
        for (int k = 0; k < 6; k++) begin
            vecs[k].a = '0;
            vecs[k].b = '0;
        end
        vecs[0].sgn = 1'b0; vecs[0].len = 16; vecs[0].exp_d = 32'd16; vecs[0].exp_s = 1'b0;
        for (int i = 0; i < 16; i++) begin vecs[0].a[i] = 32'd1; vecs[0].b[i] = 32'd1; end
        vecs[1].sgn = 1'b0; vecs[1].len = 4; vecs[1].exp_d = 32'd70; vecs[1].exp_s = 1'b0;
        for (int i = 0; i < 4; i++) begin vecs[1].a[i] = 32'(i + 1); vecs[1].b[i] = 32'(i + 5); end
        vecs[2].sgn = 1'b1; vecs[2].len = 2; vecs[2].exp_d = 32'hFFFFFFD9; vecs[2].exp_s = 1'b0;
        vecs[2].a[0] = 32'hFFFFFFFD; vecs[2].a[1] = 32'd4;
        vecs[2].b[0] = 32'd5;        vecs[2].b[1] = 32'hFFFFFFFA;
        vecs[3].sgn = 1'b0; vecs[3].len = 2; vecs[3].exp_d = 32'hFFFFFFFF; vecs[3].exp_s = 1'b1;
        for (int i = 0; i < 2; i++) begin vecs[3].a[i] = 32'hFFFFFFFF; vecs[3].b[i] = 32'hFFFFFFFF; end
        vecs[4].sgn = 1'b1; vecs[4].len = 1; vecs[4].exp_d = 32'h7FFFFFFF; vecs[4].exp_s = 1'b1;
        vecs[4].a[0] = 32'h80000000; vecs[4].b[0] = 32'h80000000;
        vecs[5].sgn = 1'b1; vecs[5].len = 1; vecs[5].exp_d = 32'h80000000; vecs[5].exp_s = 1'b1;
        vecs[5].a[0] = 32'h80000000; vecs[5].b[0] = 32'h7FFFFFFF;

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                beat_a[i] = vecs[k].a[i];
                beat_b[i] = vecs[k].b[i];
            end
            run_op(vecs[k].sgn, vecs[k].len, vecs[k].exp_d, vecs[k].exp_s, 1'b0,
                   $sformatf("vec%0d", k));
        end

        // Gapped load, stalled output, START pulses while busy
        for (int i = 0; i < 3; i++) begin beat_a[i] = 32'(i + 1); beat_b[i] = 32'(i + 1); end
        sb.push_back(exp_t'{d: 32'd14, s: 1'b0});
        START = 1'b1; SIGNED = 1'b0; LEN = LW'(3);
        tick();
        OUT_READY = 1'b0;
        load(3, 1'b1, acc);
        START = 1'b0;
        check("hs_beats", 64'(acc), 64'd3);
        wait_result("hs", 3);
        for (int c = 0; c < 5; c++) begin
            START = (c == 2);
            tick();
            check($sformatf("hs_hold%0d", c), 64'({OUT_VALID, OUT_SAT, OUT_DATA}),
                  64'({1'b1, 1'b0, 32'd14}));
        end
        OUT_READY = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("hs_release", 64'({OUT_VALID, BUSY}), 64'd0);
        tick();
        check("hs_start_ignored", 64'({BUSY, IN_READY}), 64'd0);

        // LEN=0: result the cycle after START
        sb.push_back(exp_t'{d: 32'd0, s: 1'b0});
        START = 1'b1; SIGNED = 1'b1; LEN = '0;
        tick();
        START = 1'b0;
        wait_result("len0", 0);
        tick();
        check("len0_idle", 64'(BUSY), 64'd0);

        // LEN above DEPTH clamps to DEPTH beats
        for (int i = 0; i < 17; i++) begin beat_a[i] = 32'(i + 1); beat_b[i] = 32'(i + 1); end
        sb.push_back(exp_t'{d: 32'd1496, s: 1'b0});
        START = 1'b1; SIGNED = 1'b0; LEN = LW'(17);
        tick();
        START = 1'b0;
        acc = 0;
        for (int c = 0; c < 17; c++) begin
            IN_VALID = 1'b1; IN_A = beat_a[c]; IN_B = beat_b[c];
            if (IN_READY) acc++;
            tick();
        end
        IN_VALID = 1'b0;
        check("len17_beats", 64'(acc), 64'd16);
        wait_result("len17", 15);
        tick();

        // Reset mid-MAC abandons the operation
        for (int i = 0; i < 4; i++) begin beat_a[i] = 32'h00012345; beat_b[i] = 32'h00000777; end
        START = 1'b1; SIGNED = 1'b0; LEN = LW'(4);
        tick();
        START = 1'b0;
        load(4, 1'b0, acc);
        tick();
        tick();
        RSTN = 1'b0;
        #1;
        check("rst_mid_outs", 64'({IN_READY, OUT_VALID, OUT_SAT, BUSY}), 64'd0);
        check("rst_mid_data", 64'(OUT_DATA), 64'd0);
        tick();
        RSTN = 1'b1;
        tick();
        check("rst_idle", 64'({BUSY, OUT_VALID}), 64'd0);
        beat_a[0] = 32'd2; beat_b[0] = 32'd3;
        run_op(1'b0, 1, 32'd6, 1'b0, 1'b0, "post_rst");

        // Random operations against the reference model
        for (int r = 0; r < 6; r++) begin
            rs = 1'($urandom_range(0, 1));
            rl = int'($urandom_range(1, 16));
            for (int i = 0; i < rl; i++) begin
                if (r < 3) begin
                    beat_a[i] = 32'($signed(8'($urandom)));
                    beat_b[i] = 32'($signed(8'($urandom)));
                end else begin
                    beat_a[i] = $urandom;
                    beat_b[i] = $urandom;
                end
            end
            model(rs, rl, md, ms);
            run_op(rs, rl, md, ms, 1'(r % 2), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
